icff_drain: RTL and testbench

- Downstream consumer of the instruction-cache fill FIFO.
- Pops one cache line of 16-bit words from the FIFO and writes them into the I-cache data array.
- Then writes the tag/valid entry and pulses completion to the fetch controller.
- Sits between the fill FIFO read port and the I-cache data/tag RAM write ports; all logic runs on the CPU clock.

---
 rtl/icff_drain.sv | 153 +++++++++++++++
 tb/tb_icff_drain.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icff_drain.sv
// icff_drain: pops one I-cache line from the fill FIFO into the data RAM, then writes the tag entry.
// Optional macro ICFF_CWF_EN adds a critical-word-first forward port (cwf_vld/cwf_data).
module icff_drain #(
  parameter  int LINE_WORDS = 8,
  parameter  int IDX_BITS   = 6,
  parameter  int ADDR_BITS  = 16,
  localparam int OFS_BITS   = $clog2(LINE_WORDS),
  localparam int TAG_BITS   = ADDR_BITS - IDX_BITS - OFS_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fill_req,
  input  logic [ADDR_BITS-1:0]         fill_addr,
  input  logic                         fill_abort,
  output logic                         fill_busy,
  output logic                         fill_done,
  input  logic [15:0]                  ff_do,
  input  logic                         ff_empty,
  output logic                         ff_re,
  output logic                         dw_we,
  output logic [IDX_BITS+OFS_BITS-1:0] dw_addr,
  output logic [15:0]                  dw_data,
  output logic                         tw_we,
  output logic [IDX_BITS-1:0]          tw_idx,
  output logic [TAG_BITS-1:0]          tw_tag,
`ifdef ICFF_CWF_EN
  output logic                         cwf_vld,
  output logic [15:0]                  cwf_data,
`endif
  output logic                         tw_valid
);

  typedef enum logic [1:0] {IDLE, INV, FILL, TAG} state_t;

  localparam logic [OFS_BITS:0]   RD_FULL = (OFS_BITS+1)'(LINE_WORDS);
  localparam logic [OFS_BITS-1:0] WR_LAST = OFS_BITS'(LINE_WORDS - 1);

  state_t              state, state_nx;
  logic [TAG_BITS-1:0] tag_q;
  logic [IDX_BITS-1:0] idx_q;
  logic [OFS_BITS:0]   rd_cnt;
  logic [OFS_BITS-1:0] wr_cnt;
  logic                rd_pend;
  logic                abort_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Counters and the abort flag are cleared on the way into INV so every fill starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q      <= '0;
      idx_q      <= '0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      rd_pend    <= 1'b0;
      abort_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rd_pend <= 1'b0;
          if (fill_req) begin
            tag_q      <= fill_addr[ADDR_BITS-1 -: TAG_BITS];
            idx_q      <= fill_addr[OFS_BITS +: IDX_BITS];
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            abort_flag <= 1'b0;
          end
        end
        INV: begin
          if (fill_abort) abort_flag <= 1'b1;
        end
        FILL: begin
          if (fill_abort) abort_flag <= 1'b1;
          rd_pend <= ff_re;
          if (ff_re)   rd_cnt <= rd_cnt + 1'b1;
          if (rd_pend) wr_cnt <= wr_cnt + 1'b1;
        end
        default: rd_pend <= 1'b0;
      endcase
    end
  end

  // An aborted fill keeps draining so the FIFO stays line-aligned; only the RAM writes are masked.
  always_comb begin
    state_nx  = state;
    ff_re     = 1'b0;
    dw_we     = 1'b0;
    dw_addr   = '0;
    dw_data   = '0;
    tw_we     = 1'b0;
    tw_idx    = '0;
    tw_tag    = '0;
    tw_valid  = 1'b0;
    fill_done = 1'b0;
    case (state)
      IDLE: begin
        if (fill_req) state_nx = INV;
      end
      INV: begin
        tw_we    = 1'b1;
        tw_idx   = idx_q;
        tw_tag   = tag_q;
        state_nx = FILL;
      end
      FILL: begin
        ff_re = !ff_empty && (rd_cnt != RD_FULL);
        if (rd_pend) begin
          dw_we   = !abort_flag;
          dw_addr = {idx_q, wr_cnt};
          dw_data = ff_do;
          if (wr_cnt == WR_LAST) state_nx = TAG;
        end
      end
      TAG: begin
        tw_we     = 1'b1;
        tw_idx    = idx_q;
        tw_tag    = tag_q;
        tw_valid  = !abort_flag && !fill_abort;
        fill_done = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign fill_busy = (state != IDLE);

`ifdef ICFF_CWF_EN
  logic [OFS_BITS-1:0] ofs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          ofs_q <= '0;
    else if (state == IDLE && fill_req) ofs_q <= fill_addr[OFS_BITS-1:0];
  end

  // The missed word is forwarded as it lands in the data RAM, unless the fill is being abandoned.
  always_comb begin
    cwf_vld  = 1'b0;
    cwf_data = '0;
    if (state == FILL && rd_pend && wr_cnt == ofs_q && !abort_flag && !fill_abort) begin
      cwf_vld  = 1'b1;
      cwf_data = ff_do;
    end
  end
`else
  logic unused_ofs;
  assign unused_ofs = ^fill_addr[OFS_BITS-1:0];
`endif

endmodule

// File: tb/tb_icff_drain.sv
// tb_icff_drain: directed tests for icff_drain with a small behavioural fill FIFO.
module tb_icff_drain;

  localparam int LW   = 8;
  localparam int NREC = 40;
  localparam int NONE = -10;

  logic        clk = 1'b0;
  logic        rst;
  logic        fill_req, fill_abort;
  logic [15:0] fill_addr;
  logic        fill_busy, fill_done;
  logic [15:0] ff_do;
  logic        ff_empty, ff_re;
  logic        dw_we;
  logic [8:0]  dw_addr;
  logic [15:0] dw_data;
  logic        tw_we, tw_valid;
  logic [5:0]  tw_idx;
  logic [6:0]  tw_tag;
`ifdef ICFF_CWF_EN
  logic        cwf_vld;
  logic [15:0] cwf_data;
`endif

  int n_checks = 0;
  int n_errors = 0;

  icff_drain dut (
    .clk(clk), .rst(rst),
    .fill_req(fill_req), .fill_addr(fill_addr), .fill_abort(fill_abort),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .ff_do(ff_do), .ff_empty(ff_empty), .ff_re(ff_re),
    .dw_we(dw_we), .dw_addr(dw_addr), .dw_data(dw_data),
    .tw_we(tw_we), .tw_idx(tw_idx), .tw_tag(tw_tag),
`ifdef ICFF_CWF_EN
    .cwf_vld(cwf_vld), .cwf_data(cwf_data),
`endif
    .tw_valid(tw_valid)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data appears the cycle after ff_re; shares rst with the DUT.
  logic [15:0] fifo_mem [64];
  int wr_ptr  = 0;
  int rd_ptr  = 0;
  int pop_cnt = 0;
  assign ff_empty = (wr_ptr == rd_ptr);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= wr_ptr;
      ff_do  <= '0;
    end else if (ff_re && !ff_empty) begin
      ff_do   <= fifo_mem[rd_ptr[5:0]];
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  task automatic push_word(input logic [15:0] w);
    fifo_mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic preload(input logic [15:0] base);
    for (int k = 0; k < LW; k++) push_word(base + 16'(k));
  endtask

  logic        rec_ff_re [NREC];
  logic        rec_dw_we [NREC];
  logic [8:0]  rec_dw_addr [NREC];
  logic [15:0] rec_dw_data [NREC];
  logic        rec_tw_we [NREC];
  logic        rec_tw_valid [NREC];
  logic [5:0]  rec_tw_idx [NREC];
  logic [6:0]  rec_tw_tag [NREC];
  logic        rec_done [NREC];
  logic        rec_busy [NREC];
`ifdef ICFF_CWF_EN
  logic        rec_cwf_vld [NREC];
  logic [15:0] rec_cwf_data [NREC];
`endif
  int re_empty_viol;

  // Cycle 0 is the fill_req cycle; outputs are recorded on the falling edge of each cycle.
  task automatic run_fill(input logic [15:0] addr, input logic [15:0] base, input int feed_period,
                          input int abort_cyc, input int req2_cyc, input logic [15:0] addr2,
                          input int rst_cyc);
    int fed = 0;
    re_empty_viol = 0;
    for (int c = 0; c < NREC; c++) begin
      @(posedge clk); #1;
      fill_req   = (c == 0) || (c == req2_cyc);
      fill_addr  = (c == req2_cyc) ? addr2 : addr;
      fill_abort = (c == abort_cyc);
      if (c == rst_cyc)     rst = 1'b1;
      if (c == rst_cyc + 2) rst = 1'b0;
      if (feed_period > 0 && (c % feed_period) == 0 && fed < LW) begin
        push_word(base + 16'(fed));
        fed++;
      end
      @(negedge clk);
      rec_ff_re[c]    = ff_re;
      rec_dw_we[c]    = dw_we;
      rec_dw_addr[c]  = dw_addr;
      rec_dw_data[c]  = dw_data;
      rec_tw_we[c]    = tw_we;
      rec_tw_valid[c] = tw_valid;
      rec_tw_idx[c]   = tw_idx;
      rec_tw_tag[c]   = tw_tag;
      rec_done[c]     = fill_done;
      rec_busy[c]     = fill_busy;
`ifdef ICFF_CWF_EN
      rec_cwf_vld[c]  = cwf_vld;
      rec_cwf_data[c] = cwf_data;
`endif
      if (ff_re && ff_empty) re_empty_viol++;
    end
    fill_req   = 1'b0;
    fill_abort = 1'b0;
    fill_addr  = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1; fill_req = 1'b0; fill_abort = 1'b0; fill_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({ff_re, dw_we, tw_we, tw_valid, fill_done, fill_busy} !== 6'b0) begin
      n_errors++;
      $display("[TB] FAIL reset_ctrl got=%b exp=000000", {ff_re, dw_we, tw_we, tw_valid, fill_done, fill_busy});
    end
    n_checks++;
    if ({dw_addr, dw_data, tw_idx, tw_tag} !== '0) begin
      n_errors++;
      $display("[TB] FAIL reset_data got=%h exp=0", {dw_addr, dw_data, tw_idx, tw_tag});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    fill_abort = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    fill_abort = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fill_busy !== 1'b0 || tw_we !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL idle_abort busy=%b tw_we=%b exp=0/0", fill_busy, tw_we);
    end
  endtask

  task automatic test_basic_fill;
    logic e_re, e_we, e_tw, e_done, e_busy;
    int p0;
    preload(16'h1000);
    p0 = pop_cnt;
    run_fill(16'h1B45, 16'h0, 0, NONE, NONE, 16'h0, NONE);
    for (int c = 0; c < 14; c++) begin
      e_re = (c >= 2 && c <= 9);
      e_we = (c >= 3 && c <= 10);
      e_tw = (c == 1 || c == 11);
      e_done = (c == 11);
      e_busy = (c >= 1 && c <= 11);
      n_checks++;
      if ({rec_ff_re[c], rec_dw_we[c], rec_tw_we[c], rec_done[c], rec_busy[c]} !== {e_re, e_we, e_tw, e_done, e_busy}) begin
        n_errors++;
        $display("[TB] FAIL basic_ctrl c=%0d got re/we/tw/done/busy=%b exp=%b", c,
                 {rec_ff_re[c], rec_dw_we[c], rec_tw_we[c], rec_done[c], rec_busy[c]}, {e_re, e_we, e_tw, e_done, e_busy});
      end
      if (e_we) begin
        n_checks++;
        if (rec_dw_addr[c] !== 9'h140 + 9'(c - 3) || rec_dw_data[c] !== 16'h1000 + 16'(c - 3)) begin
          n_errors++;
          $display("[TB] FAIL basic_write c=%0d got addr=%h data=%h exp addr=%h data=%h", c,
                   rec_dw_addr[c], rec_dw_data[c], 9'h140 + 9'(c - 3), 16'h1000 + 16'(c - 3));
        end
      end
      if (e_tw) begin
        n_checks++;
        if (rec_tw_idx[c] !== 6'h28 || rec_tw_tag[c] !== 7'h0D || rec_tw_valid[c] !== (c == 11)) begin
          n_errors++;
          $display("[TB] FAIL basic_tag c=%0d got idx=%h tag=%h valid=%b exp idx=28 tag=0d valid=%b", c,
                   rec_tw_idx[c], rec_tw_tag[c], rec_tw_valid[c], (c == 11));
        end
      end
    end
    n_checks++;
    if (pop_cnt - p0 !== 8 || ff_empty !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL basic_pops got=%0d empty=%b exp=8 empty=1", pop_cnt - p0, ff_empty);
    end
  endtask

  task automatic test_slow_feed;
    int k = 0;
    int ndone = 0;
    int done_cyc = -1;
    run_fill(16'h0A10, 16'h2000, 3, NONE, NONE, 16'h0, NONE);
    n_checks++;
    if (re_empty_viol !== 0) begin
      n_errors++;
      $display("[TB] FAIL slow_re_empty got=%0d exp=0", re_empty_viol);
    end
    for (int c = 0; c < NREC; c++) begin
      if (rec_dw_we[c]) begin
        n_checks++;
        if (rec_dw_addr[c] !== 9'h010 + 9'(k) || rec_dw_data[c] !== 16'h2000 + 16'(k)) begin
          n_errors++;
          $display("[TB] FAIL slow_write k=%0d got addr=%h data=%h exp addr=%h data=%h", k,
                   rec_dw_addr[c], rec_dw_data[c], 9'h010 + 9'(k), 16'h2000 + 16'(k));
        end
        k++;
      end
      if (rec_done[c]) begin
        ndone++;
        done_cyc = c;
      end
    end
    n_checks++;
    if (k !== 8) begin
      n_errors++;
      $display("[TB] FAIL slow_nwrites got=%0d exp=8", k);
    end
    n_checks++;
    if (ndone !== 1 || done_cyc !== 23) begin
      n_errors++;
      $display("[TB] FAIL slow_done got count=%0d cyc=%0d exp count=1 cyc=23", ndone, done_cyc);
    end
    n_checks++;
    if (rec_tw_valid[23] !== 1'b1 || rec_tw_tag[23] !== 7'h05 || rec_tw_idx[23] !== 6'h02) begin
      n_errors++;
      $display("[TB] FAIL slow_tag got valid=%b tag=%h idx=%h exp 1/05/02", rec_tw_valid[23], rec_tw_tag[23], rec_tw_idx[23]);
    end
  endtask

  task automatic test_abort;
    int p0;
    int nre = 0;
    preload(16'h3000);
    p0 = pop_cnt;
    run_fill(16'h1B45, 16'h0, 0, 5, NONE, 16'h0, NONE);
    for (int c = 3; c <= 10; c++) begin
      n_checks++;
      if (rec_dw_we[c] !== (c <= 5)) begin
        n_errors++;
        $display("[TB] FAIL abort_dw_we c=%0d got=%b exp=%b", c, rec_dw_we[c], (c <= 5));
      end
    end
    for (int c = 0; c < NREC; c++) if (rec_ff_re[c]) nre++;
    n_checks++;
    if (nre !== 8 || pop_cnt - p0 !== 8 || ff_empty !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL abort_drain got re=%0d pops=%0d empty=%b exp 8/8/1", nre, pop_cnt - p0, ff_empty);
    end
    n_checks++;
    if (rec_tw_we[11] !== 1'b1 || rec_tw_valid[11] !== 1'b0 || rec_done[11] !== 1'b1 || rec_busy[12] !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL abort_tag got we=%b valid=%b done=%b busy12=%b exp 1/0/1/0",
               rec_tw_we[11], rec_tw_valid[11], rec_done[11], rec_busy[12]);
    end
  endtask

  task automatic test_abort_in_tag;
    int nwr = 0;
    preload(16'h3800);
    run_fill(16'h1B45, 16'h0, 0, 11, NONE, 16'h0, NONE);
    for (int c = 0; c < NREC; c++) if (rec_dw_we[c]) nwr++;
    n_checks++;
    if (nwr !== 8) begin
      n_errors++;
      $display("[TB] FAIL tag_abort_writes got=%0d exp=8", nwr);
    end
    n_checks++;
    if (rec_tw_we[11] !== 1'b1 || rec_tw_valid[11] !== 1'b0 || rec_done[11] !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL tag_abort got we=%b valid=%b done=%b exp 1/0/1", rec_tw_we[11], rec_tw_valid[11], rec_done[11]);
    end
  endtask

  task automatic test_req_while_busy;
    int nwr = 0;
    int ndone = 0;
    int ntw = 0;
    preload(16'h6000);
    run_fill(16'h1B45, 16'h0, 0, NONE, 4, 16'h0208, NONE);
    for (int c = 0; c < NREC; c++) begin
      if (rec_dw_we[c]) begin
        nwr++;
        n_checks++;
        if (rec_dw_addr[c][8:3] !== 6'h28) begin
          n_errors++;
          $display("[TB] FAIL busy_req_idx c=%0d got=%h exp=28", c, rec_dw_addr[c][8:3]);
        end
      end
      if (rec_done[c])  ndone++;
      if (rec_tw_we[c]) ntw++;
    end
    n_checks++;
    if (nwr !== 8 || ndone !== 1 || ntw !== 2) begin
      n_errors++;
      $display("[TB] FAIL busy_req_counts got wr=%0d done=%0d tw=%0d exp 8/1/2", nwr, ndone, ntw);
    end
    n_checks++;
    if (rec_tw_tag[11] !== 7'h0D || rec_tw_idx[11] !== 6'h28 || rec_tw_valid[11] !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL busy_req_tag got tag=%h idx=%h valid=%b exp 0d/28/1", rec_tw_tag[11], rec_tw_idx[11], rec_tw_valid[11]);
    end
  endtask

  task automatic test_reset_mid_fill;
    int nwr = 0;
    int ntw = 0;
    int ndone = 0;
    preload(16'h4000);
    run_fill(16'h1B45, 16'h0, 0, NONE, NONE, 16'h0, 6);
    for (int c = 0; c < NREC; c++) begin
      if (rec_dw_we[c]) nwr++;
      if (rec_tw_we[c] && c != 1) ntw++;
      if (rec_done[c]) ndone++;
    end
    n_checks++;
    if (nwr !== 3 || ntw !== 0 || ndone !== 0) begin
      n_errors++;
      $display("[TB] FAIL rst_mid_counts got wr=%0d tw=%0d done=%0d exp 3/0/0", nwr, ntw, ndone);
    end
    n_checks++;
    if ({rec_busy[6], rec_ff_re[6], rec_dw_we[6], rec_tw_we[6]} !== 4'b0 || rec_dw_addr[6] !== 9'h0 || rec_dw_data[6] !== 16'h0) begin
      n_errors++;
      $display("[TB] FAIL rst_mid_outputs got busy/re/we/tw=%b addr=%h data=%h exp 0", 
               {rec_busy[6], rec_ff_re[6], rec_dw_we[6], rec_tw_we[6]}, rec_dw_addr[6], rec_dw_data[6]);
    end
    n_checks++;
    if (ff_empty !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL rst_mid_fifo got empty=%b exp=1", ff_empty);
    end
    nwr = 0;
    preload(16'h5000);
    run_fill(16'h0A10, 16'h0, 0, NONE, NONE, 16'h0, NONE);
    for (int c = 0; c < NREC; c++) if (rec_dw_we[c]) nwr++;
    n_checks++;
    if (nwr !== 8 || rec_dw_data[10] !== 16'h5007 || rec_dw_addr[10] !== 9'h017) begin
      n_errors++;
      $display("[TB] FAIL rst_refill_writes got n=%0d data10=%h addr10=%h exp 8/5007/017", nwr, rec_dw_data[10], rec_dw_addr[10]);
    end
    n_checks++;
    if (rec_done[11] !== 1'b1 || rec_tw_valid[11] !== 1'b1 || rec_tw_tag[11] !== 7'h05) begin
      n_errors++;
      $display("[TB] FAIL rst_refill_tag got done=%b valid=%b tag=%h exp 1/1/05", rec_done[11], rec_tw_valid[11], rec_tw_tag[11]);
    end
  endtask

`ifdef ICFF_CWF_EN
  task automatic test_cwf;
    int ncwf;
    preload(16'h1000);
    run_fill(16'h1B45, 16'h0, 0, NONE, NONE, 16'h0, NONE);
    for (int c = 0; c < NREC; c++) begin
      n_checks++;
      if (rec_cwf_vld[c] !== (c == 8)) begin
        n_errors++;
        $display("[TB] FAIL cwf_vld c=%0d got=%b exp=%b", c, rec_cwf_vld[c], (c == 8));
      end
    end
    n_checks++;
    if (rec_cwf_data[8] !== 16'h1005) begin
      n_errors++;
      $display("[TB] FAIL cwf_data got=%h exp=1005", rec_cwf_data[8]);
    end
    preload(16'h1100);
    run_fill(16'h1B45, 16'h0, 0, 4, NONE, 16'h0, NONE);
    ncwf = 0;
    for (int c = 0; c < NREC; c++) if (rec_cwf_vld[c]) ncwf++;
    n_checks++;
    if (ncwf !== 0) begin
      n_errors++;
      $display("[TB] FAIL cwf_early_abort got=%0d exp=0", ncwf);
    end
    preload(16'h1200);
    run_fill(16'h1B45, 16'h0, 0, 8, NONE, 16'h0, NONE);
    ncwf = 0;
    for (int c = 0; c < NREC; c++) if (rec_cwf_vld[c]) ncwf++;
    n_checks++;
    if (ncwf !== 0 || rec_dw_we[8] !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL cwf_same_cycle_abort got cwf=%0d we8=%b exp 0/1", ncwf, rec_dw_we[8]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_fill();
    test_slow_feed();
    test_abort();
    test_abort_in_tag();
    test_req_while_busy();
    test_reset_mid_fill();
`ifdef ICFF_CWF_EN
    test_cwf();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
